// File: rtl/hw3_addmul_pipe_if.sv
// Valid/ready operand and result bus for the hw3_addmul_pipe datapath.
// The slave modport is the datapath's view; the master modport is the driver's view.
interface hw3_addmul_pipe_if #(
    parameter int W  = 8,
    parameter int OW = 2 * W
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  c;
    logic [1:0]    op;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] d;

    modport master (
        output in_valid, a, b, c, op, out_ready,
        input  in_ready, out_valid, d
    );

    modport slave (
        input  in_valid, a, b, c, op, out_ready,
        output in_ready, out_valid, d
    );
endinterface

// File: rtl/hw3_addmul_pipe.sv
// Two-stage (a+/-b)*c pipeline with multiply-accumulate mode and valid/ready flow control.
// Optional gated-load counter output gate_cnt is enabled by defining HW3_GATE_CNT_EN.
module hw3_addmul_pipe #(
    parameter int W  = 8,
    parameter int OW = 2 * W
) (
    input  logic clk,
    input  logic reset,
    hw3_addmul_pipe_if.slave bus
`ifdef HW3_GATE_CNT_EN
    ,
    output logic [15:0] gate_cnt
`endif
);

    logic          s1_valid;
    logic [OW-1:0] s1_sum;
    logic [W-1:0]  s1_c;
    logic [1:0]    s1_op;
    logic          s1_cz;
    logic          out_valid_q;
    logic [OW-1:0] d_q;
    logic [OW-1:0] acc;

    logic [OW-1:0] a_ext;
    logic [OW-1:0] b_ext;
    logic [OW-1:0] c_ext;
    logic [OW-1:0] sum_next;
    logic [OW-1:0] prod;
    logic [OW-1:0] acc_sum;
    logic          s2_adv;
    logic          in_ready;
    logic          accept;
    logic          s2_load;

    assign s2_adv   = !out_valid_q | bus.out_ready;
    assign in_ready = !s1_valid | s2_adv;
    assign accept   = bus.in_valid & in_ready;
    assign s2_load  = s1_valid & s2_adv;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.d         = d_q;

    // A gated item leaves the operand registers stale, so its product is forced to zero here.
    always_comb begin
        a_ext    = {{(OW-W){1'b0}}, bus.a};
        b_ext    = {{(OW-W){1'b0}}, bus.b};
        c_ext    = {{(OW-W){1'b0}}, s1_c};
        sum_next = a_ext + b_ext;
        case (bus.op)
            2'b00:   sum_next = a_ext - b_ext;
            2'b10:   sum_next = b_ext - a_ext;
            default: sum_next = a_ext + b_ext;
        endcase
        prod    = s1_cz ? '0 : s1_sum * c_ext;
        acc_sum = acc + prod;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_c     <= '0;
            s1_op    <= '0;
            s1_cz    <= 1'b0;
        end else begin
            if (accept) begin
                s1_op <= bus.op;
                s1_cz <= (bus.c == '0);
                if (bus.c != '0) begin
                    s1_sum <= sum_next;
                    s1_c   <= bus.c;
                end
            end
            if (accept)
                s1_valid <= 1'b1;
            else if (s2_adv)
                s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            d_q         <= '0;
            acc         <= '0;
        end else begin
            if (s2_adv)
                out_valid_q <= s1_valid;
            if (s2_load) begin
                if (s1_op == 2'b11) begin
                    acc <= acc_sum;
                    d_q <= acc_sum;
                end else begin
                    d_q <= prod;
                end
            end
        end
    end

`ifdef HW3_GATE_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            gate_cnt <= '0;
        else if (s2_load && s1_cz)
            gate_cnt <= gate_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_hw3_addmul_pipe.sv
// Directed testbench for hw3_addmul_pipe (W=8): arithmetic, gating, accumulate,
// stall behaviour and mid-operation reset, with hand-computed expected results.
module tb_hw3_addmul_pipe;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    hw3_addmul_pipe_if #(.W(8), .OW(16)) bus ();

`ifdef HW3_GATE_CNT_EN
    logic [15:0] gate_cnt;
`endif

    hw3_addmul_pipe #(.W(8), .OW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef HW3_GATE_CNT_EN
        ,
        .gate_cnt (gate_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single point of comparison; every check in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Sends one item through an idle pipeline and checks latency and result.
    task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input logic [7:0] c, input logic [15:0] expected);
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        bus.c         = c;
        #1;
        checkOutput({tag, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput({tag, "_early_valid"}, bus.out_valid, 0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_valid"}, bus.out_valid, 1);
        checkOutput({tag, "_d"}, bus.d, expected);
    endtask

    task automatic drain();
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] got[$];
    logic [15:0] prev_d;
    logic        prev_stall;
    int          accepted;

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = '0;
        bus.b         = '0;
        bus.c         = '0;
        bus.op        = '0;
        #1;
        checkOutput("reset_out_valid", bus.out_valid, 0);
        checkOutput("reset_d", bus.d, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset_in_ready", bus.in_ready, 1);
`ifdef HW3_GATE_CNT_EN
        checkOutput("reset_gate_cnt", gate_cnt, 0);
`endif

        applyStimulus("add", 2'b01, 8'h10, 8'h05, 8'h03, 16'h003F);
        applyStimulus("sub_wrap", 2'b00, 8'h05, 8'h10, 8'h02, 16'hFFEA);
        applyStimulus("rsub", 2'b10, 8'h05, 8'h10, 8'h02, 16'h0016);
        applyStimulus("gate_zero", 2'b01, 8'hFF, 8'hFF, 8'h00, 16'h0000);
`ifdef HW3_GATE_CNT_EN
        checkOutput("gate_cnt_1", gate_cnt, 1);
`endif
        applyStimulus("after_gate", 2'b01, 8'h02, 8'h01, 8'h03, 16'h0009);

        applyStimulus("acc_1", 2'b11, 8'h01, 8'h02, 8'h04, 16'h000C);
        applyStimulus("acc_2", 2'b11, 8'h03, 8'h03, 8'h02, 16'h0018);
        applyStimulus("acc_bypass", 2'b01, 8'h01, 8'h01, 8'h01, 16'h0002);
        applyStimulus("acc_gated", 2'b11, 8'h05, 8'h05, 8'h00, 16'h0018);
        applyStimulus("acc_hold", 2'b11, 8'h00, 8'h00, 8'h01, 16'h0018);
`ifdef HW3_GATE_CNT_EN
        checkOutput("gate_cnt_2", gate_cnt, 2);
`endif

        // Five back-to-back items, a=1..5, b=1, c=2, with out_ready low in cycles 1..3.
        drain();
        accepted   = 0;
        prev_stall = 1'b0;
        prev_d     = '0;
        for (int k = 0; k < 20 && got.size() < 5; k++) begin
            @(negedge clk);
            bus.out_ready = !(k >= 1 && k <= 3);
            if (accepted < 5) begin
                bus.in_valid = 1'b1;
                bus.op       = 2'b01;
                bus.a        = 8'(accepted + 1);
                bus.b        = 8'h01;
                bus.c        = 8'h02;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (prev_stall)
                checkOutput("stall_hold_d", bus.d, prev_d);
            if (k == 2) begin
                checkOutput("stall_in_ready", bus.in_ready, 0);
                checkOutput("stall_accepts", accepted, 2);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_d     = bus.d;
            if (bus.out_valid && bus.out_ready)
                got.push_back(bus.d);
            if (bus.in_valid && bus.in_ready)
                accepted++;
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checkOutput("stream_count", got.size(), 5);
        for (int i = 0; i < got.size(); i++)
            checkOutput($sformatf("stream_%0d", i), got[i], 32'(2 * (i + 2)));

        // Two items in flight (one in stage 1, one at the output) with acc=0x18, then reset.
        drain();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = 2'b01;
        bus.a        = 8'h01;
        bus.b        = 8'h01;
        bus.c        = 8'h01;
        @(negedge clk);
        bus.a = 8'h02;
        @(posedge clk);
        #2;
        checkOutput("inflight_valid", bus.out_valid, 1);
        reset = 1'b1;
        #1;
        checkOutput("midreset_out_valid", bus.out_valid, 0);
        checkOutput("midreset_d", bus.d, 0);
`ifdef HW3_GATE_CNT_EN
        checkOutput("midreset_gate_cnt", gate_cnt, 0);
`endif
        @(negedge clk);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checkOutput("postreset_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        checkOutput("postreset_no_output", bus.out_valid, 0);
        applyStimulus("acc_after_reset", 2'b11, 8'h01, 8'h01, 8'h01, 16'h0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
